mul_issue_ctrl: RTL

- Issue and response stage that wraps the 1-cycle-pipelined 32x32 Booth/Wallace multiplier.
- Upstream: accepts valid/ready multiply requests carrying an op and a tag, registers the operands, and drives the multiplier's sign/x/y inputs.
- Downstream: tracks the multiplier's fixed latency, selects the low or high 32-bit word of the 64-bit product, and buffers responses in a credit-protected FIFO. The multiplier pipeline has no stall, so backpressure is absorbed here.

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_issue_ctrl_if.sv | 25 ++
 rtl/mul_resp_fifo.sv | 47 ++++
 rtl/mul_issue_ctrl.sv | 88 ++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: op encodings, word widths and product word-select helpers shared by the multiply issue stage
package mul_pkg;
  localparam int PROD_W = 64;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {
    MUL_OP_MUL   = 2'b00,
    MUL_OP_MULH  = 2'b01,
    MUL_OP_MULHU = 2'b10,
    MUL_OP_MULLU = 2'b11
  } mul_op_e;
  function automatic logic op_signed(mul_op_e op);
    return op == MUL_OP_MUL || op == MUL_OP_MULH;
  endfunction
  function automatic logic [WORD_W-1:0] sel_word(mul_op_e op, logic [PROD_W-1:0] p);
    return (op == MUL_OP_MULH || op == MUL_OP_MULHU) ? p[PROD_W-1:WORD_W] : p[WORD_W-1:0];
  endfunction
endpackage

// File: rtl/mul_issue_ctrl_if.sv
// mul_issue_ctrl_if: request and response valid/ready channels of the multiply issue stage
interface mul_issue_ctrl_if
  import mul_pkg::*;
#(
  parameter int TAG_W = 4
) ();
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [WORD_W-1:0] req_x;
  logic [WORD_W-1:0] req_y;
  logic [TAG_W-1:0]  req_tag;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;
  modport master (
    output req_valid, req_op, req_x, req_y, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );
  modport slave (
    input  req_valid, req_op, req_x, req_y, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/mul_resp_fifo.sv
// mul_resp_fifo: in-order wrap-around FIFO with async reset and synchronous clear
module mul_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [AW-1:0] nxt(logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // pointer and occupancy update; clear wins over push/pop
  always_comb begin
    wr_d  = clr ? '0 : push ? nxt(wr_q) : wr_q;
    rd_d  = clr ? '0 : pop ? nxt(rd_q) : rd_q;
    cnt_d = clr ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  // pointer registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  // storage needs no reset; occupancy decides what is visible
  always_ff @(posedge clk)
    if (push && !clr) mem_q[wr_q] <= wdata;
  assign rdata = mem_q[rd_q];
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/response wrapper for a pipelined 32x32 multiplier; define MUL_FLUSH_EN to add a synchronous flush input
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = 1,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MUL_FLUSH_EN
  input  logic              flush,
`endif
  mul_issue_ctrl_if.slave   bus,
  output logic              mul_sign,
  output logic [WORD_W-1:0] mul_x,
  output logic [WORD_W-1:0] mul_y,
  input  logic [PROD_W-1:0] mul_result
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic             v;
    mul_op_e          op;
    logic [TAG_W-1:0] tag;
  } stage_t;
  logic                  do_flush, accept, push, pop, fifo_full, fifo_empty;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  sign_q, sign_d;
  logic [WORD_W-1:0]     x_q, x_d, y_q, y_d;
  logic [TAG_W+WORD_W-1:0] rdata;
  stage_t                pipe_q [MUL_LAT+1];
  stage_t                pipe_d [MUL_LAT+1];
`ifdef MUL_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif
  // handshakes, credit accounting and operand capture; ready depends only on registered credits
  always_comb begin
    bus.req_ready  = !rst && cnt_q < CW'(DEPTH) && !do_flush;
    accept         = bus.req_valid && bus.req_ready;
    bus.resp_valid = !fifo_empty && !do_flush;
    pop            = bus.resp_valid && bus.resp_ready;
    cnt_d          = do_flush ? '0 : cnt_q + CW'(accept) - CW'(pop);
    sign_d         = accept ? op_signed(mul_op_e'(bus.req_op)) : sign_q;
    x_d            = accept ? bus.req_x : x_q;
    y_d            = accept ? bus.req_y : y_q;
  end
  // valid/op/tag travel beside the multiplier so each result can be tagged and word-selected
  always_comb begin
    pipe_d[0] = '{v: accept, op: mul_op_e'(bus.req_op), tag: bus.req_tag};
    for (int i = 1; i <= MUL_LAT; i++) pipe_d[i] = pipe_q[i-1];
    for (int i = 0; i <= MUL_LAT; i++) if (do_flush) pipe_d[i].v = 1'b0;
    push = pipe_q[MUL_LAT].v && !do_flush;
  end
  // state registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q  <= '0;
      sign_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      for (int i = 0; i <= MUL_LAT; i++) pipe_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sign_q <= sign_d;
      x_q    <= x_d;
      y_q    <= y_d;
      for (int i = 0; i <= MUL_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  assign mul_sign = sign_q;
  assign mul_x    = x_q;
  assign mul_y    = y_q;
  mul_resp_fifo #(.W(TAG_W + WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (do_flush),
    .push  (push),
    .pop   (pop),
    .wdata ({pipe_q[MUL_LAT].tag, sel_word(pipe_q[MUL_LAT].op, mul_result)}),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  assign {bus.resp_tag, bus.resp_data} = rdata;
  // credits bound the in-flight count, so the multiplier never delivers into a full FIFO
  assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
endmodule
